// File: rtl/bus_pkg.sv
// Shared constants and types for the internal 16-bit bus mux/demux pair.
package bus_pkg;
    localparam int WORD_W  = 16;
    localparam int SEL_W   = 3;
    localparam int NUM_SRC = 8;
    localparam int CNT_W   = 4;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;
endpackage

// File: rtl/rr_arbiter8.sv
// Round-robin grant picker: keeps an eligible owner, otherwise scans from last_grant+1.
// Latency: combinational. Backpressure: none; the caller gates the grant.
module rr_arbiter8
    import bus_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SEL_W-1:0]   last_grant_i,
    input  logic [SEL_W-1:0]   owner_i,
    input  logic               own_elig_i,
    output logic [SEL_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o
);
    logic [SEL_W-1:0] cand;

    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        cand      = '0;
        if (own_elig_i && req_i[owner_i]) begin
            gnt_idx_o = owner_i;
            gnt_vld_o = 1'b1;
        end else begin
            // k = NUM_SRC wraps back to last_grant itself, so it is checked last
            for (int k = 1; k <= NUM_SRC; k++) begin
                cand = last_grant_i + SEL_W'(k);
                if (!gnt_vld_o && req_i[cand]) begin
                    gnt_idx_o = cand;
                    gnt_vld_o = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/bus_mux_arbiter8.sv
// 8-to-1 bus merge with bounded-burst round-robin arbitration and a registered output.
// Latency: 1 cycle from acceptance to out_valid; full throughput with out_ready held high.
// Backpressure: out_valid && !out_ready holds the output and drops every in_ready.
module bus_mux_arbiter8
    import bus_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] in_data,
    input  logic [NUM_SRC-1:0]     in_valid,
    output logic [NUM_SRC-1:0]     in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_valid,
    input  logic                   out_ready
);
    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;

    logic             load_en;
    logic             own_elig;
    logic             accept;
    logic             drain;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_vld;

    assign load_en  = !out_valid_q || out_ready;
    assign own_elig = (state_q == ARB_OWN) && (burst_cnt_q < CNT_W'(BURST - 1));
    assign accept   = load_en && gnt_vld;
    assign drain    = out_valid_q && out_ready && !gnt_vld;

    rr_arbiter8 u_arb (
        .req_i        (in_valid),
        .last_grant_i (last_grant_q),
        .owner_i      (last_grant_q),
        .own_elig_i   (own_elig),
        .gnt_idx_o    (gnt_idx),
        .gnt_vld_o    (gnt_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= SEL_W'(NUM_SRC - 1);
            burst_cnt_q  <= '0;
            out_data_q   <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ARB_OWN;
        end else if (drain) begin
            state_d = ARB_IDLE;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        out_valid_d  = out_valid_q;
        if (accept) begin
            out_data_d   = in_data[gnt_idx*WIDTH +: WIDTH];
            out_sel_d    = gnt_idx;
            out_valid_d  = 1'b1;
            last_grant_d = gnt_idx;
            // An exhausted owner that re-wins (nobody else valid) starts a fresh burst
            if (own_elig && gnt_idx == last_grant_q) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end else begin
                burst_cnt_d = '0;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
            burst_cnt_d = '0;
        end
    end

    // Gated by rst_n so sources see in_ready drop the moment reset asserts
    always_comb begin
        in_ready = '0;
        if (rst_n && accept) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
endmodule
